// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, refill states and word select for the cache refill path
package cache_pkg;

   localparam int ADDR_W   = 15;
   localparam int LINE_W   = 128;
   localparam int WORD_W   = 32;
   localparam int OFFSET_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      MEM_REQ,
      MEM_WAIT,
      FILL,
      RESPOND
   } state_t;

   function automatic logic [WORD_W-1:0] word_select(input logic [LINE_W-1:0]   line,
                                                     input logic [OFFSET_W-1:0] offset);
      logic [WORD_W-1:0] w;
      case (offset)
         2'd0:    w = line[WORD_W-1:0];
         2'd1:    w = line[2*WORD_W-1:WORD_W];
         2'd2:    w = line[3*WORD_W-1:2*WORD_W];
         default: w = line[4*WORD_W-1:3*WORD_W];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - serves cache hits in one cycle, refills the line from memory on a miss
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic                       cache_hit,
   input  logic [LINE_W-1:0]          cache_rdata,
   output logic                       stall,
   output logic                       resp_valid,
   output logic [WORD_W-1:0]          resp_data,
   output logic                       err,
   output logic                       mem_rd_en,
   output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
   input  logic [LINE_W-1:0]          mem_rdata,
   input  logic                       mem_rdata_valid,
   output logic                       fill_en,
   output logic [ADDR_W-1:0]          fill_addr,
   output logic [LINE_W-1:0]          fill_data,
   output logic [CNT_W-1:0]           hit_count,
   output logic [CNT_W-1:0]           miss_count
);

   localparam int              TO_W   = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

   state_t            state, next_state;
   logic [ADDR_W-1:0] addr_q;
   logic [TO_W-1:0]   to_cnt;
   logic              hit_inc, miss_inc;

   always_comb begin
      next_state = state;
      hit_inc    = 1'b0;
      miss_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (cache_hit) begin
                  hit_inc = 1'b1;
               end else begin
                  miss_inc   = 1'b1;
                  next_state = MEM_REQ;
               end
            end
         end
         MEM_REQ:  next_state = MEM_WAIT;
         MEM_WAIT: begin
            if (mem_rdata_valid) begin
               next_state = FILL;
            end else if (to_cnt == TO_MAX) begin
               next_state = RESPOND;
            end
         end
         FILL:     next_state = RESPOND;
         RESPOND:  next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Strobes are registered from next_state so they line up with the state they belong to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         stall      <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         err        <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         fill_en    <= 1'b0;
         fill_addr  <= '0;
         fill_data  <= '0;
         addr_q     <= '0;
         to_cnt     <= '0;
      end else begin
         state      <= next_state;
         stall      <= (next_state != IDLE);
         mem_rd_en  <= (next_state == MEM_REQ);
         fill_en    <= (next_state == FILL);
         resp_valid <= hit_inc || (next_state == RESPOND);
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (hit_inc) begin
                  resp_data <= word_select(cache_rdata, req_addr[OFFSET_W-1:0]);
               end
               if (miss_inc) begin
                  addr_q   <= req_addr;
                  mem_addr <= req_addr[ADDR_W-1:OFFSET_W];
               end
            end
            MEM_REQ: to_cnt <= '0;
            MEM_WAIT: begin
               if (mem_rdata_valid) begin
                  fill_data <= mem_rdata;
                  fill_addr <= {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
               end else if (to_cnt == TO_MAX) begin
                  resp_data <= '0;
                  err       <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            FILL: resp_data <= word_select(fill_data, addr_q[OFFSET_W-1:0]);
            default: ;
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_count)
   );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

   localparam int TIMEOUT = 255;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req_valid = 1'b0;
   logic [14:0]  req_addr = '0;
   logic         cache_hit = 1'b0;
   logic [127:0] cache_rdata = '0;
   logic         stall, resp_valid, err, mem_rd_en, fill_en;
   logic [31:0]  resp_data;
   logic [12:0]  mem_addr;
   logic [127:0] mem_rdata = '0;
   logic         mem_rdata_valid = 1'b0;
   logic [14:0]  fill_addr;
   logic [127:0] fill_data;
   logic [15:0]  hit_count, miss_count;

   always #5 clk = ~clk;

   cache_refill_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_addr        (req_addr),
      .cache_hit       (cache_hit),
      .cache_rdata     (cache_rdata),
      .stall           (stall),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .err             (err),
      .mem_rd_en       (mem_rd_en),
      .mem_addr        (mem_addr),
      .mem_rdata       (mem_rdata),
      .mem_rdata_valid (mem_rdata_valid),
      .fill_en         (fill_en),
      .fill_addr       (fill_addr),
      .fill_data       (fill_data),
      .hit_count       (hit_count),
      .miss_count      (miss_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pick(input logic [127:0] line, input logic [1:0] off);
      logic [127:0] sh;
      sh = line >> (32 * int'(off));
      return sh[31:0];
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Model: a miss accepted at edge c gives read request in period c, valid seen in
   // period p, fill in p+1 and response in p+2; with no valid, response in c+TIMEOUT+2.
   int           cyc, c_miss, fill_at, resp_at;
   bit           busy, to, hit_now, preset;
   logic [14:0]  m_addr;
   logic [127:0] m_line;
   logic [31:0]  hit_word;
   logic [15:0]  m_hit, m_miss;

   initial preset = 1'b0;

   always @(posedge clk or negedge rst or posedge preset) begin
      if (!rst) begin
         cyc = 0; busy = 0; to = 0; hit_now = 0;
         c_miss = -10; fill_at = -1; resp_at = -1;
         m_hit = '0; m_miss = '0; m_addr = '0; m_line = '0; hit_word = '0;
      end else if (preset) begin
         m_hit = 16'hFFFE;
      end else begin
         cyc++;
         hit_now = 0;
         if (!busy) begin
            if (req_valid && cache_hit) begin
               hit_now  = 1;
               hit_word = pick(cache_rdata, req_addr[1:0]);
               m_hit    = sat_inc(m_hit);
            end else if (req_valid) begin
               busy = 1; c_miss = cyc; m_addr = req_addr;
               fill_at = -1; resp_at = -1; to = 0;
               m_miss = sat_inc(m_miss);
            end
         end else if (resp_at < 0) begin
            if ((cyc - 1 >= c_miss + 1) && mem_rdata_valid) begin
               m_line = mem_rdata; fill_at = cyc; resp_at = cyc + 1;
            end else if (cyc - 1 == c_miss + 1 + TIMEOUT) begin
               resp_at = cyc; to = 1;
            end
         end else if (cyc == resp_at + 1) begin
            busy = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         logic e_rd, e_fill, e_rv;
         e_rd   = busy && (cyc == c_miss);
         e_fill = busy && (cyc == fill_at);
         e_rv   = hit_now || (busy && (cyc == resp_at));
         check("stall", stall, busy);
         check("mem_rd_en", mem_rd_en, e_rd);
         check("fill_en", fill_en, e_fill);
         check("resp_valid", resp_valid, e_rv);
         check("err", err, busy && (cyc == resp_at) && to);
         check("hit_count", hit_count, m_hit);
         check("miss_count", miss_count, m_miss);
         if (e_rd) check("mem_addr", mem_addr, m_addr[14:2]);
         if (e_fill) begin
            check("fill_addr", fill_addr, {m_addr[14:2], 2'b00});
            check("fill_data", fill_data, m_line);
         end
         if (e_rv) check("resp_data", resp_data,
                         hit_now ? hit_word : (to ? 32'h0 : pick(m_line, m_addr[1:0])));
      end
   end

   // Memory: answers L cycles after the read request; mem_lat=0 never answers.
   int           mem_lat = 0;
   int           countdown = 0;
   logic [127:0] mem_line = '0;
   bit           late_valid = 1'b0;

   always @(negedge clk) begin
      mem_rdata_valid = late_valid;
      if (late_valid) mem_rdata = mem_line;
      if (!rst) begin
         countdown = 0;
      end else begin
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               mem_rdata_valid = 1'b1;
               mem_rdata       = mem_line;
            end
         end
         if (mem_rd_en && (mem_lat > 0)) countdown = mem_lat;
      end
   end

   task automatic drive(input logic v, input logic [14:0] a, input logic h, input logic [127:0] d);
      @(negedge clk);
      req_valid = v; req_addr = a; cache_hit = h; cache_rdata = d;
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_stall", stall, 1'b0);
      check("rst_hit_count", hit_count, 16'd0);
      check("rst_miss_count", miss_count, 16'd0);

      drive(1'b1, 15'h0005, 1'b1, 128'h44444444_33333333_22222222_11111111);
      drive(1'b0, 15'h0, 1'b0, 128'h0);
      check("hit_resp_valid", resp_valid, 1'b1);
      check("hit_resp_data", resp_data, 32'h22222222);
      check("hit_count_1", hit_count, 16'd1);

      for (int i = 0; i < 4; i++)
         drive(1'b1, 15'(i * 17), 1'b1, {32'(i * 4 + 3), 32'(i * 4 + 2), 32'(i * 4 + 1), 32'(i * 4)});
      drive(1'b0, 15'h0, 1'b0, 128'h0);

      mem_lat  = 2;
      mem_line = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
      drive(1'b1, 15'h0013, 1'b0, 128'h0);
      drive(1'b1, 15'h0022, 1'b1, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
      check("miss_rd_en", mem_rd_en, 1'b1);
      check("miss_mem_addr", mem_addr, 13'h0004);
      check("miss_stall", stall, 1'b1);
      check("miss_count_1", miss_count, 16'd1);
      repeat (3) @(negedge clk);
      check("miss_fill_en", fill_en, 1'b1);
      check("miss_fill_addr", fill_addr, 15'h0010);
      @(negedge clk);
      check("miss_resp_valid", resp_valid, 1'b1);
      check("miss_resp_data", resp_data, 32'hDDDDDDDD);
      check("miss_hits_frozen", hit_count, 16'd5);
      @(negedge clk);
      check("miss_stall_end", stall, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      check("held_resp_data", resp_data, 32'h89ABCDEF);
      check("held_hit_count", hit_count, 16'd6);

      mem_lat  = 1;
      mem_line = 128'h0F0F0F0F_12345678_9ABCDEF0_CAFEBABE;
      drive(1'b1, 15'h01A3, 1'b0, 128'h0);
      drive(1'b0, 15'h0, 1'b0, 128'h0);
      repeat (6) @(negedge clk);

      mem_lat = 0;
      drive(1'b1, 15'h0007, 1'b0, 128'h0);
      drive(1'b0, 15'h0, 1'b0, 128'h0);
      k = 1;
      while (!resp_valid && (k < 400)) begin
         @(negedge clk);
         k++;
      end
      check("timeout_latency", k, TIMEOUT + 3);
      check("timeout_err", err, 1'b1);
      check("timeout_resp_data", resp_data, 32'h0);
      @(negedge clk);
      check("timeout_stall_end", stall, 1'b0);

      drive(1'b1, 15'h0031, 1'b0, 128'h0);
      drive(1'b0, 15'h0, 1'b0, 128'h0);
      repeat (4) @(negedge clk);
      check("pre_rst_stall", stall, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("arst_stall", stall, 1'b0);
      check("arst_mem_addr", mem_addr, 13'h0);
      check("arst_fill_data", fill_data, 128'h0);
      check("arst_fill_addr", fill_addr, 15'h0);
      check("arst_resp", {resp_valid, err, mem_rd_en, fill_en, resp_data}, 36'h0);
      check("arst_counts", {hit_count, miss_count}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 late_valid = 1'b1;
      @(posedge clk);
      #1 late_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("late_valid_stall", stall, 1'b0);
      check("late_valid_no_fill", fill_en, 1'b0);

      @(posedge clk);
      #1;
      force dut.u_hit_cnt.count = 16'hFFFE;
      preset = 1'b1;
      #1;
      release dut.u_hit_cnt.count;
      preset = 1'b0;
      for (int i = 0; i < 3; i++)
         drive(1'b1, 15'(i), 1'b1, 128'h55555555_66666666_77777777_88888888);
      drive(1'b0, 15'h0, 1'b0, 128'h0);
      check("sat_hit_count", hit_count, 16'hFFFF);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss-handling controller between the CPU-side request port, the direct-mapped cache and the 128-bit-line data memory. It accepts word-address requests and serves hits from the cache line in one cycle. On a miss it stalls the requester, fetches the line from memory over a valid-handshake, writes the line into the cache and then returns the requested 32-bit word. It also keeps saturating hit/miss counters for performance monitoring.

Parameters:
ADDR_W, 15, word address width; [1:0] is the word offset, [14:2] is the line address
LINE_W, 128, cache and memory line width (4 words)
WORD_W, 32, returned word width
TIMEOUT, 255, max MEM_WAIT cycles before abort
CNT_W, 16, hit/miss counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request strobe; sampled only when stall=0
req_addr  in  ADDR_W  requested word address
cache_hit  in  1  cache tag-match for req_addr, combinational, same cycle
cache_rdata  in  LINE_W  cache line for req_addr, same cycle
stall  out  1  controller busy; requester holds its request
resp_valid  out  1  one-cycle pulse; resp_data is valid
resp_data  out  WORD_W  selected word
err  out  1  one-cycle pulse with resp_valid on timeout
mem_rd_en  out  1  one-cycle memory read request
mem_addr  out  ADDR_W-2  line address to memory
mem_rdata  in  LINE_W  memory line
mem_rdata_valid  in  1  memory line valid
fill_en  out  1  one-cycle cache write strobe
fill_addr  out  ADDR_W  address of the line being filled
fill_data  out  LINE_W  line written into the cache
hit_count  out  CNT_W  number of hits
miss_count  out  CNT_W  number of misses

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs return to 0: stall, resp_valid, resp_data, err, mem_rd_en, mem_addr, fill_en, fill_addr, fill_data, hit_count and miss_count. The latched address, latched line and timeout counter clear. A reset mid-miss abandons the fetch; any later mem_rdata_valid arriving in IDLE is ignored.
- stall = (state != IDLE), registered.
- States:
  - IDLE:
    - req_valid=1 and cache_hit=1: next cycle resp_valid=1, resp_data = word req_addr[1:0] of cache_rdata, hit_count++. Stay in IDLE. A back-to-back request every cycle is allowed.
    - req_valid=1 and cache_hit=0: latch req_addr, miss_count++, go to MEM_REQ.
  - MEM_REQ: mem_rd_en=1 for exactly this cycle, mem_addr = latched[14:2]. Go to MEM_WAIT and clear the timeout counter.
  - MEM_WAIT: on mem_rdata_valid=1, latch mem_rdata and go to FILL. Otherwise increment the counter. When the counter reaches TIMEOUT, go to RESPOND with the error flag set.
  - FILL: fill_en=1, fill_addr = latched address with [1:0]=0, fill_data = latched line. Go to RESPOND.
  - RESPOND: resp_valid=1 and resp_data = selected word of the latched line. On timeout, resp_data=0 and err=1. Go to IDLE.
- mem_rdata_valid is sampled only in MEM_WAIT. The memory guarantees L>=1 cycles from mem_rd_en.
- Word select: offset 00→[31:0], 01→[63:32], 10→[95:64], 11→[127:96].
- Latency:
  - Hit: resp_valid 1 cycle after the request edge.
  - Miss: resp_valid L+3 cycles after the request edge, where L is the mem_rd_en→mem_rdata_valid delay.
- Counters saturate at all-ones and do not wrap.
- req_valid while stall=1 is ignored and causes no counter change.
- Hit and miss outcomes are mutually exclusive per accepted request.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W, LINE_W, WORD_W and OFFSET_W=2 constants
  - the state enum IDLE/MEM_REQ/MEM_WAIT/FILL/RESPOND
  - a word_select(line, offset) function reused by the cache
- One sub-module, sat_counter (parameter CNT_W; inputs inc, clk, rst), instantiated twice for the hit and miss counters.

Test Plan:
- Reset with rst=0 mid-MEM_WAIT → all outputs 0 immediately (asynchronous). After release, state=IDLE, stall=0, and a late mem_rdata_valid is ignored.
- Hit: req_addr=15'h0005, cache_hit=1, cache_rdata=128'h44444444_33333333_22222222_11111111 → next cycle resp_valid=1, resp_data=32'h22222222, hit_count=1.
- Miss with L=2: req_addr=15'h0013, cache_hit=0 → mem_rd_en at cycle 1 with mem_addr=13'h0004. mem_rdata=128'hDDDD..._CCCC..._BBBB..._AAAA... valid at cycle 3 → fill_en at cycle 4 with fill_addr=15'h0010, then resp_valid at cycle 5 with resp_data=32'hDDDDDDDD. miss_count=1 and stall=1 during cycles 1–5.
- Requests while stalled: req_valid held high with a different address during a miss → no extra mem_rd_en and counters unchanged. The held request is served in the cycle after RESPOND.
- Timeout: miss with mem_rdata_valid never asserted → resp_valid=1 and err=1 with resp_data=0, TIMEOUT+3 cycles after the request. fill_en is never asserted.
- Saturation: force hit_count=16'hFFFE, then send 3 hits → hit_count holds 16'hFFFF.
